// File: rtl/axi4lite_master_bridge.sv
// Single-beat command/response to AXI4-Lite master bridge, one transaction in flight.
// Define AXI_BRIDGE_STATS_EN to add 16-bit write/read/error transaction counters.
module axi4lite_master_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    aresetn,
`ifdef AXI_BRIDGE_STATS_EN
   output logic [15:0]             stat_wr_cnt,
   output logic [15:0]             stat_rd_cnt,
   output logic [15:0]             stat_err_cnt,
`endif
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_write,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

   state_t                  state, state_next;
   logic                    aw_done, aw_done_next, w_done, w_done_next;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_next;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_next;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_next;
   logic                    cmd_ready_next, awvalid_next, wvalid_next, bready_next;
   logic                    arvalid_next, rready_next, rsp_valid_next, rsp_write_next;
   logic [DATA_WIDTH-1:0]   rsp_rdata_next;
   logic [1:0]              rsp_resp_next;
   logic                    aw_hs, w_hs, b_hs, r_hs;

   assign aw_hs = m_axi_awvalid & m_axi_awready;
   assign w_hs  = m_axi_wvalid & m_axi_wready;
   assign b_hs  = (state == WR_RESP) & m_axi_bvalid & m_axi_bready;
   assign r_hs  = (state == RD_RESP) & m_axi_rvalid & m_axi_rready;

   // Address and data share one capture register per field; they only load in IDLE,
   // so they are stable for the whole time any valid is high.
   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_wstrb  = wstrb_q;

   always_comb begin
      state_next     = state;
      aw_done_next   = aw_done;
      w_done_next    = w_done;
      addr_next      = addr_q;
      wdata_next     = wdata_q;
      wstrb_next     = wstrb_q;
      awvalid_next   = m_axi_awvalid;
      wvalid_next    = m_axi_wvalid;
      bready_next    = m_axi_bready;
      arvalid_next   = m_axi_arvalid;
      rready_next    = m_axi_rready;
      rsp_valid_next = rsp_valid;
      rsp_rdata_next = rsp_rdata;
      rsp_resp_next  = rsp_resp;
      rsp_write_next = rsp_write;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_next      = cmd_addr;
               wdata_next     = cmd_wdata;
               wstrb_next     = cmd_wstrb;
               rsp_write_next = cmd_write;
               if (cmd_write) begin
                  state_next   = WR_REQ;
                  awvalid_next = 1'b1;
                  wvalid_next  = 1'b1;
               end else begin
                  state_next   = RD_REQ;
                  arvalid_next = 1'b1;
               end
            end
         end
         WR_REQ: begin
            // AW and W may finish in either order; each valid drops after its own handshake.
            aw_done_next = aw_done | aw_hs;
            w_done_next  = w_done | w_hs;
            if (aw_hs) awvalid_next = 1'b0;
            if (w_hs)  wvalid_next  = 1'b0;
            if (aw_done_next && w_done_next) begin
               state_next   = WR_RESP;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               bready_next  = 1'b1;
            end
         end
         WR_RESP: begin
            if (b_hs) begin
               state_next     = RSP;
               bready_next    = 1'b0;
               rsp_resp_next  = m_axi_bresp;
               rsp_rdata_next = '0;
               rsp_valid_next = 1'b1;
            end
         end
         RD_REQ: begin
            if (m_axi_arvalid && m_axi_arready) begin
               state_next   = RD_RESP;
               arvalid_next = 1'b0;
               rready_next  = 1'b1;
            end
         end
         RD_RESP: begin
            if (r_hs) begin
               state_next     = RSP;
               rready_next    = 1'b0;
               rsp_resp_next  = m_axi_rresp;
               rsp_rdata_next = m_axi_rdata;
               rsp_valid_next = 1'b1;
            end
         end
         RSP: begin
            if (rsp_valid && rsp_ready) begin
               state_next     = IDLE;
               rsp_valid_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
      cmd_ready_next = (state_next == IDLE);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state         <= IDLE;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         cmd_ready     <= 1'b1;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         rsp_write     <= 1'b0;
      end else begin
         state         <= state_next;
         aw_done       <= aw_done_next;
         w_done        <= w_done_next;
         addr_q        <= addr_next;
         wdata_q       <= wdata_next;
         wstrb_q       <= wstrb_next;
         cmd_ready     <= cmd_ready_next;
         m_axi_awvalid <= awvalid_next;
         m_axi_wvalid  <= wvalid_next;
         m_axi_bready  <= bready_next;
         m_axi_arvalid <= arvalid_next;
         m_axi_rready  <= rready_next;
         rsp_valid     <= rsp_valid_next;
         rsp_rdata     <= rsp_rdata_next;
         rsp_resp      <= rsp_resp_next;
         rsp_write     <= rsp_write_next;
      end
   end

`ifdef AXI_BRIDGE_STATS_EN
   // Counters wrap naturally; the error count follows bit 1 of whichever response completed.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         stat_wr_cnt  <= 16'd0;
         stat_rd_cnt  <= 16'd0;
         stat_err_cnt <= 16'd0;
      end else begin
         if (b_hs) stat_wr_cnt <= stat_wr_cnt + 16'd1;
         if (r_hs) stat_rd_cnt <= stat_rd_cnt + 16'd1;
         if ((b_hs && m_axi_bresp[1]) || (r_hs && m_axi_rresp[1]))
            stat_err_cnt <= stat_err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Table-driven bench for axi4lite_master_bridge with a delay-programmable AXI slave model.
// Stat counter checks are compiled in when AXI_BRIDGE_STATS_EN is defined.
module tb_axi4lite_master_bridge;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
`ifdef AXI_BRIDGE_STATS_EN
   logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 aclk = ~aclk;

   axi4lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
`ifdef AXI_BRIDGE_STATS_EN
      .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt),
`endif
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_write(rsp_write),
      .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   // One directed transaction plus the slave's per-channel wait cycles and the
   // hand-computed cycle (counted from the acceptance edge) at which rsp_valid appears.
   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [3:0]  aw_dly;
      logic [3:0]  w_dly;
      logic [3:0]  b_dly;
      logic [3:0]  ar_dly;
      logic [3:0]  r_dly;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic [3:0]  rsp_dly;
      logic [3:0]  lat;
   } vec_t;

   vec_t vec [8];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clearSlave();
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
   endtask

   task automatic applyStimulus(input vec_t v);
      int cyc, rsp_cyc, aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_count;
      bit aw_seen, w_seen, ar_seen;
      logic [31:0] exp_rdata;
      exp_rdata = v.write ? 32'h0 : v.rdata;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; b_count = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; rsp_cyc = 0;
      @(negedge aclk);
      checkOutput("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
      cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
      @(negedge aclk);
      cmd_valid = 1'b0;
      if (v.write) begin
         checkOutput("awvalid_n1", awvalid, 1);
         checkOutput("wvalid_n1", wvalid, 1);
      end else begin
         checkOutput("arvalid_n1", arvalid, 1);
      end
      checkOutput("cmd_ready_busy", cmd_ready, 0);
      cyc = 1;
      while (!rsp_valid && cyc < 40) begin
         if (aw_seen) checkOutput("awvalid_dropped", awvalid, 0);
         if (w_seen)  checkOutput("wvalid_dropped", wvalid, 0);
         if (awvalid) checkOutput("awaddr_stable", awaddr, v.addr);
         if (wvalid) begin
            checkOutput("wdata_stable", wdata, v.wdata);
            checkOutput("wstrb_stable", wstrb, v.wstrb);
         end
         if (arvalid) checkOutput("araddr_stable", araddr, v.addr);
         if (ar_seen) checkOutput("rready_held", rready, 1);
         awready = awvalid && (aw_cnt >= int'(v.aw_dly));
         if (awvalid) aw_cnt++;
         aw_seen = aw_seen | awready;
         wready = wvalid && (w_cnt >= int'(v.w_dly));
         if (wvalid) w_cnt++;
         w_seen = w_seen | wready;
         bvalid = bready && (b_cnt >= int'(v.b_dly));
         bresp = v.resp;
         if (bready) b_cnt++;
         if (bvalid) b_count++;
         arready = arvalid && (ar_cnt >= int'(v.ar_dly));
         if (arvalid) ar_cnt++;
         ar_seen = ar_seen | arready;
         rvalid = rready && (r_cnt >= int'(v.r_dly));
         rdata = rvalid ? v.rdata : 32'h0;
         rresp = v.resp;
         if (rready) r_cnt++;
         if (rvalid) ar_seen = 0;
         @(negedge aclk);
         cyc++;
         if (rsp_valid) rsp_cyc = cyc;
      end
      clearSlave();
      checkOutput("rsp_valid_timeout", rsp_valid, 1);
      checkOutput("rsp_latency", rsp_cyc, v.lat);
      checkOutput("rsp_resp", rsp_resp, v.resp);
      checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
      checkOutput("rsp_write", rsp_write, v.write);
      if (v.write) checkOutput("b_handshakes", b_count, 1);
      for (int k = 0; k < int'(v.rsp_dly); k++) begin
         @(negedge aclk);
         checkOutput("rsp_valid_hold", rsp_valid, 1);
         checkOutput("rsp_rdata_hold", rsp_rdata, exp_rdata);
         checkOutput("cmd_ready_hold", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge aclk);
      rsp_ready = 1'b0;
      checkOutput("rsp_valid_clear", rsp_valid, 0);
      checkOutput("cmd_ready_back", cmd_ready, 1);
   endtask

   initial begin
      //           wr  addr      wdata         strb  aw w  b  ar r  resp   rdata         rspd lat
      vec[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 32'h0,        4'd0, 4'd3};
      vec[1] = '{1'b1, 32'h14, 32'hCAFEF00D, 4'h3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 32'h0,        4'd0, 4'd6};
      vec[2] = '{1'b0, 32'h20, 32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 2'b00, 32'h12345678, 4'd0, 4'd5};
      vec[3] = '{1'b0, 32'h24, 32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 2'b00, 32'hA5A5A5A5, 4'd5, 4'd4};
      vec[4] = '{1'b1, 32'h30, 32'h0BADF00D, 4'hC, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b10, 32'h0,        4'd0, 4'd3};
      vec[5] = '{1'b0, 32'h34, 32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b11, 32'hFFFF0001, 4'd0, 4'd3};
      vec[6] = '{1'b1, 32'h38, 32'h01020304, 4'h1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd0, 2'b01, 32'h0,        4'd2, 4'd6};
      vec[7] = '{1'b0, 32'h3C, 32'h0,        4'h0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 2'b00, 32'h55AA55AA, 4'd0, 4'd5};

      aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
      clearSlave();
      repeat (3) @(negedge aclk);
      checkOutput("reset_cmd_ready", cmd_ready, 1);
      checkOutput("reset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
      checkOutput("reset_rsp", {rsp_rdata, rsp_resp, rsp_write}, 0);
      aresetn = 1'b1;

      // Abort a write while AW is still waiting on a stalled slave.
      @(negedge aclk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40;
      cmd_wdata = 32'h11112222; cmd_wstrb = 4'hF;
      @(negedge aclk);
      cmd_valid = 1'b0;
      checkOutput("abort_awvalid_before", awvalid, 1);
      aresetn = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      checkOutput("abort_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
      checkOutput("abort_cmd_ready", cmd_ready, 1);
      checkOutput("abort_awaddr", awaddr, 0);
      repeat (3) begin
         @(negedge aclk);
         checkOutput("abort_no_rsp", rsp_valid, 0);
      end

      for (int i = 0; i < 8; i++) applyStimulus(vec[i]);

`ifdef AXI_BRIDGE_STATS_EN
      checkOutput("stat_wr_cnt", stat_wr_cnt, 4);
      checkOutput("stat_rd_cnt", stat_rd_cnt, 4);
      checkOutput("stat_err_cnt", stat_err_cnt, 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
